pass_requester: RTL

//  Initiator side of the traffic-light 'pass' interface: turns a raw pedestrian button into a clean pass request.

---
 rtl/pass_req_pkg.sv | 14 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/pass_requester.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pass_req_pkg.sv
// State encoding and default timing constants shared by the pedestrian pass requester.
package pass_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_ACK_TO       = 256;
    localparam int DEF_HOLDOFF_CYC  = 2048;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability debouncer and a registered
// one-cycle pulse on each debounced rising edge.
module btn_debounce
    import pass_req_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic req_evt
);

    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          evt_q, evt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // dcnt_q counts earlier consecutive disagreeing cycles; the current one completes the run.
    always_comb begin
        level_d = level_q;
        dcnt_d  = '0;
        evt_d   = 1'b0;
        if (sync2_q != level_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                evt_d   = sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            evt_q   <= evt_d;
        end
    end

    assign req_evt = evt_q;

endmodule

// File: rtl/pass_requester.sv
// Initiator side of the traffic-light pass interface: request FSM, shared cycle counter,
// pending flag and registered outputs. Optional wait-lamp blinking under PASS_LAMP_BLINK_EN.
module pass_requester
    import pass_req_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int ACK_TO       = DEF_ACK_TO,
    parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
    parameter int CNT_W        = 12
`ifdef PASS_LAMP_BLINK_EN
    ,
    parameter int BLINK_LOG2   = 6
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic R,
    input  logic G,
    input  logic Y,
    output logic pass,
    output logic wait_lamp,
    output logic serviced,
    output logic timeout_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               pending_q, pending_d;
    logic               pass_q, pass_d;
    logic               wait_q, wait_d;
    logic               serviced_q, serviced_d;
    logic               timeout_q, timeout_d;
    logic               req_evt, green_ok, req_active;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .req_evt (req_evt)
    );

    // Lamp combinations other than pure green (e.g. G with Y during a fault) do not acknowledge.
    assign green_ok = G & ~R & ~Y;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            pass_q     <= 1'b0;
            wait_q     <= 1'b0;
            serviced_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            pass_q     <= pass_d;
            wait_q     <= wait_d;
            serviced_q <= serviced_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                pending_d = 1'b0;
                if (req_evt) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (green_ok || (cnt_q == CNT_W'(ACK_TO - 1))) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                // A press on the expiry cycle itself still counts as pending.
                pending_d = pending_q | req_evt;
                if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
                    state_d   = pending_d ? ST_ASSERT : ST_IDLE;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

`ifdef PASS_LAMP_BLINK_EN
    logic [BLINK_LOG2:0] blink_q, blink_d;
    logic                active_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q  <= '0;
            active_q <= 1'b0;
        end else begin
            blink_q  <= blink_d;
            active_q <= req_active;
        end
    end
`endif

    always_comb begin
        req_active = (state_d == ST_ASSERT) || ((state_d == ST_HOLD) && pending_d);
        pass_d     = (state_d == ST_ASSERT);
        serviced_d = (state_q == ST_ASSERT) && (state_d == ST_HOLD) && green_ok;
        timeout_d  = (state_q == ST_ASSERT) && (state_d == ST_HOLD) && !green_ok;
`ifdef PASS_LAMP_BLINK_EN
        // Restart the blink phase so the lamp is lit on the first pending cycle.
        blink_d = (req_active && !active_q) ? '0 : blink_q + {{BLINK_LOG2{1'b0}}, 1'b1};
        wait_d  = req_active && !blink_d[BLINK_LOG2];
`else
        wait_d  = req_active;
`endif
    end

    assign pass        = pass_q;
    assign wait_lamp   = wait_q;
    assign serviced    = serviced_q;
    assign timeout_err = timeout_q;

endmodule
